// File: rtl/if_id_skid_register_if.sv
// Fetch-to-decode bus: the IF response channel with its issue-ready back-pressure,
// plus the registered ID slot presented to decode and the ID/EX register.
interface if_id_skid_register_if #(
    parameter int XLEN = 32
);
    logic            IF_valid;
    logic [XLEN-1:0] IF_pc;
    logic [XLEN-1:0] IF_pc_plus_4;
    logic [31:0]     IF_instruction;
    logic            IF_branch_estimation;
    logic            fetch_ready;

    logic            ID_valid;
    logic [XLEN-1:0] ID_pc;
    logic [XLEN-1:0] ID_pc_plus_4;
    logic [31:0]     ID_instruction;
    logic            ID_branch_estimation;

    // Fetch/decode environment side.
    modport master (
        output IF_valid, IF_pc, IF_pc_plus_4, IF_instruction, IF_branch_estimation,
        input  fetch_ready,
        input  ID_valid, ID_pc, ID_pc_plus_4, ID_instruction, ID_branch_estimation
    );

    // Pipeline register side.
    modport slave (
        input  IF_valid, IF_pc, IF_pc_plus_4, IF_instruction, IF_branch_estimation,
        output fetch_ready,
        output ID_valid, ID_pc, ID_pc_plus_4, ID_instruction, ID_branch_estimation
    );
endinterface

// File: rtl/if_id_skid_register.sv
// IF/ID pipeline register with a skid FIFO that absorbs the one-cycle-late
// instruction memory response during stalls, and drops wrong-path responses after a flush.
module if_id_skid_register #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  pipeline_stall,
    if_id_skid_register_if.slave  bus,
    output logic                  overflow_error
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(DEPTH - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [31:0]     instruction;
        logic            branch_estimation;
    } entry_t;

    localparam entry_t BUBBLE = '{pc: '0, pc_plus_4: '0, instruction: 32'h0000_0013,
                                  branch_estimation: 1'b0};

    entry_t             id_q, id_d;
    logic               id_valid_q, id_valid_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               drop_next_q, drop_next_d;
    logic               overflow_q, overflow_d;

    entry_t in_entry;
    logic   in_valid;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_entry = '{pc: bus.IF_pc, pc_plus_4: bus.IF_pc_plus_4,
                        instruction: bus.IF_instruction,
                        branch_estimation: bus.IF_branch_estimation};
    // The response that follows a flush belongs to the squashed path.
    assign in_valid = bus.IF_valid & ~drop_next_q;

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path infers a latch.
        id_d        = id_q;
        id_valid_d  = id_valid_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        drop_next_d = flush;

        if (flush) begin
            id_d       = BUBBLE;
            id_valid_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else if (pipeline_stall) begin
            if (in_valid) begin
                if (count_q < CNT_FULL) begin
                    mem_d[wr_ptr_q] = in_entry;
                    wr_ptr_d        = next_ptr(wr_ptr_q);
                    count_d         = count_q + CNT_W'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end else if (count_q != '0) begin
            // Pop the head; a same-cycle arrival refills behind it, leaving count unchanged.
            id_d       = mem_q[rd_ptr_q];
            id_valid_d = 1'b1;
            rd_ptr_d   = next_ptr(rd_ptr_q);
            if (in_valid) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end else if (in_valid) begin
            id_d       = in_entry;
            id_valid_d = 1'b1;
        end else begin
            id_d       = BUBBLE;
            id_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_q        <= BUBBLE;
            id_valid_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_next_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            id_q        <= id_d;
            id_valid_q  <= id_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_next_q <= drop_next_d;
            overflow_q  <= overflow_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.fetch_ready          = (count_q < CNT_READY);
    assign bus.ID_valid             = id_valid_q;
    assign bus.ID_pc                = id_q.pc;
    assign bus.ID_pc_plus_4         = id_q.pc_plus_4;
    assign bus.ID_instruction       = id_q.instruction;
    assign bus.ID_branch_estimation = id_q.branch_estimation;
    assign overflow_error           = overflow_q;
endmodule
